// File: rtl/mult_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// FSM state encoding, Booth digit encoding, iteration count and the
// carry-lookahead block size used by the accumulator adder.
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITER  = MULT_WIDTH / 2;

    // Bits per carry-lookahead block; WIDTH+2 is always a multiple of it
    // because WIDTH is even.
    localparam int CLA_BLK    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_e;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: turns three overlapping multiplier bits into a
// digit in {-2,-1,0,+1,+2} and selects digit*mcand, sign-extended to
// WIDTH+2 bits so that -2 * (-2^(WIDTH-1)) is representable.
module booth_recoder
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [2:0]       bits,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH+1:0] pp
);

    booth_digit_e     digit_s;
    logic [WIDTH+1:0] ext_s;

    assign ext_s = {{2{mcand[WIDTH-1]}}, mcand};

    // Booth recoding of {b[i+1], b[i], b[i-1]}
    always_comb begin
        digit_s = ZERO;
        case (bits)
            3'b000:  digit_s = ZERO;
            3'b001:  digit_s = POS1;
            3'b010:  digit_s = POS1;
            3'b011:  digit_s = POS2;
            3'b100:  digit_s = NEG2;
            3'b101:  digit_s = NEG1;
            3'b110:  digit_s = NEG1;
            3'b111:  digit_s = ZERO;
            default: digit_s = ZERO;
        endcase
    end

    // Partial-product selection for the recoded digit
    always_comb begin
        pp = '0;
        case (digit_s)
            ZERO:    pp = '0;
            POS1:    pp = ext_s;
            POS2:    pp = ext_s << 1;
            NEG1:    pp = -ext_s;
            NEG2:    pp = -(ext_s << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative signed WIDTHxWIDTH multiplier, radix-4 Booth, one partial
// product per cycle accumulated through a carry-lookahead adder.
// Optional early termination is enabled by defining MULT_EARLY_TERM_EN.
//
// Product register layout: {acc_r (WIDTH+2), mplr_r (WIDTH), guard_r}.
// Each RUN cycle adds the selected partial product into acc_r and
// arithmetic-shifts the whole register right by two; after WIDTH/2 steps
// {acc_r[WIDTH-1:0], mplr_r} is the full signed product.
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int ITER = (WIDTH == MULT_WIDTH) ? MULT_ITER : (WIDTH / 2);

    // Block carry-lookahead adder over WIDTH+2 bits
    function automatic logic [WIDTH+1:0] cla_add(input logic [WIDTH+1:0] a,
                                                 input logic [WIDTH+1:0] b);
        logic [WIDTH+1:0] g;
        logic [WIDTH+1:0] p;
        logic [WIDTH+2:0] c;
        logic             bg;
        logic             bp;
        g = a & b;
        p = a ^ b;
        c = '0;
        for (int blk = 0; blk < WIDTH + 2; blk += CLA_BLK) begin
            bg = 1'b0;
            bp = 1'b1;
            for (int i = blk; i < blk + CLA_BLK; i++) begin
                c[i+1] = g[i] | (p[i] & c[i]);
                bg     = g[i] | (p[i] & bg);
                bp     = bp & p[i];
            end
            // Carry into the next block from block generate/propagate
            c[blk+CLA_BLK] = bg | (bp & c[blk]);
        end
        return p ^ c[WIDTH+1:0];
    endfunction

    mult_state_e        state_r;
    mult_state_e        state_n_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH+1:0]   acc_r;
    logic [WIDTH-1:0]   mplr_r;
    logic               guard_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   result_r;
    logic               exc_r;
    logic               rdy_r;

    logic [2:0]         bits_s;
    logic [WIDTH+1:0]   pp_s;
    logic [WIDTH+1:0]   sum_s;
    logic [2*WIDTH+1:0] step_s;
    logic [2*WIDTH+1:0] fin_s;
    logic               last_s;
    logic               done_s;
    logic               load_s;
    logic               step_en_s;
    logic               finish_s;

    assign bits_s = {mplr_r[1:0], guard_r};

    booth_recoder #(.WIDTH(WIDTH)) u_recoder (
        .bits  (bits_s),
        .mcand (mcand_r),
        .pp    (pp_s)
    );

    assign sum_s  = cla_add(acc_r, pp_s);
    assign step_s = $signed({sum_s, mplr_r}) >>> 2'd2;
    assign last_s = (cnt_r == CNT_W'(ITER - 1));

`ifdef MULT_EARLY_TERM_EN
    // Multiplier bits not yet consumed, at and above the current digit.
    logic [WIDTH-1:0] brem_r;
    logic             early_s;
    logic [CNT_W:0]   rem_s;

    // Once the unconsumed bits are uniform, every later digit is zero; the
    // current digit (which still sees the guard bit) is added, then all
    // remaining shifts are applied at once to discard the unused B bits.
    assign early_s = (&brem_r) | ~(|brem_r);
    assign rem_s   = (CNT_W+1)'(ITER) - {1'b0, cnt_r};
    assign fin_s   = $signed({sum_s, mplr_r}) >>> {rem_s, 1'b0};
    assign done_s  = last_s | early_s;

    // Shadow of the multiplier, shifted in step with the product register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            brem_r <= '0;
        end else if (load_s) begin
            brem_r <= data_operandB;
        end else if (step_en_s) begin
            brem_r <= $signed(brem_r) >>> 2'd2;
        end
    end
`else
    assign fin_s  = step_s;
    assign done_s = last_s;
`endif

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state and datapath control; a start request wins in every state
    always_comb begin
        state_n_s = state_r;
        load_s    = 1'b0;
        step_en_s = 1'b0;
        finish_s  = 1'b0;
        if (ctrl_MULT) begin
            state_n_s = RUN;
            load_s    = 1'b1;
        end else begin
            case (state_r)
                IDLE: state_n_s = IDLE;
                RUN: begin
                    step_en_s = 1'b1;
                    if (done_s) begin
                        state_n_s = DONE;
                        finish_s  = 1'b1;
                    end else begin
                        state_n_s = RUN;
                    end
                end
                DONE:    state_n_s = IDLE;
                default: state_n_s = IDLE;
            endcase
        end
    end

    // Operand latch, product register and iteration counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand_r <= '0;
            acc_r   <= '0;
            mplr_r  <= '0;
            guard_r <= 1'b0;
            cnt_r   <= '0;
        end else if (load_s) begin
            mcand_r <= data_operandA;
            acc_r   <= '0;
            mplr_r  <= data_operandB;
            guard_r <= 1'b0;
            cnt_r   <= '0;
        end else if (step_en_s) begin
            acc_r   <= step_s[2*WIDTH+1:WIDTH];
            mplr_r  <= step_s[WIDTH-1:0];
            guard_r <= mplr_r[1];
            cnt_r   <= cnt_r + CNT_W'(1);
        end
    end

    // Result, exception and ready pulse, captured on entry to DONE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_r <= '0;
            exc_r    <= 1'b0;
            rdy_r    <= 1'b0;
        end else begin
            rdy_r <= finish_s;
            if (finish_s) begin
                result_r <= fin_s[WIDTH-1:0];
                exc_r    <= (fin_s[2*WIDTH+1:WIDTH] != {(WIDTH+2){fin_s[WIDTH-1]}});
            end
        end
    end

    assign data_result    = result_r;
    assign data_exception = exc_r;
    assign data_resultRDY = rdy_r;
    assign busy           = (state_r == RUN);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq (WIDTH=32).
// Cycle numbering: the cycle in which ctrl_MULT is high is cycle 0.
module tb_booth_mult_seq;

    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    booth_mult_seq dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Drive a start in cycle 0; returns at the falling edge of cycle 1.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // From cycle 1, wait for RDY; reports its cycle and busy-low RUN cycles.
    task automatic wait_rdy(output int cyc, output bit seen, output int busy_bad);
        cyc = 1;
        seen = 1'b0;
        busy_bad = 0;
        while (!seen && cyc < 40) begin
            if (data_resultRDY === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_bad++;
                @(negedge clock);
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ctrl_MULT = 1'b1;
        data_operandA = 32'd7;
        data_operandB = 32'd9;
        repeat (3) @(negedge clock);
        n_total++; if (data_result !== 32'd0) $display("FAIL reset_result: got %h want 0", data_result); else n_pass++;
        n_total++; if (data_exception !== 1'b0) $display("FAIL reset_exc: got %b want 0", data_exception); else n_pass++;
        n_total++; if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy: got %b want 0", data_resultRDY); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy_with_start: got %b want 0", busy); else n_pass++;
        reset_n = 1'b1;
        ctrl_MULT = 1'b0;
        @(negedge clock);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_idle_after_release: busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_signed();
        logic [31:0] va [3] = '{32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        logic [31:0] vb [3] = '{32'd9, 32'd5,         32'hFFFF_FFFF};
        logic [31:0] vr [3] = '{32'd63, 32'hFFFF_FFF1, 32'd1};
        int cyc; bit seen; int bb;
        for (int k = 0; k < 3; k++) begin
            start_op(va[k], vb[k]);
            wait_rdy(cyc, seen, bb);
            n_total++; if (!seen) $display("FAIL signed%0d_rdy: no RDY within bound", k); else n_pass++;
            n_total++; if (data_result !== vr[k]) $display("FAIL signed%0d_result: got %h want %h", k, data_result, vr[k]); else n_pass++;
            n_total++; if (data_exception !== 1'b0) $display("FAIL signed%0d_exc: got %b want 0", k, data_exception); else n_pass++;
`ifndef MULT_EARLY_TERM_EN
            n_total++; if (cyc != 17) $display("FAIL signed%0d_latency: got cycle %0d want 17", k, cyc); else n_pass++;
`endif
        end
    endtask

    task automatic test_overflow();
        logic [31:0] va [4] = '{32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb [4] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE};
        logic [31:0] vr [4] = '{32'd0,         32'h8000_0000, 32'h8000_0000, 32'd0};
        logic        ve [4] = '{1'b1,          1'b1,          1'b0,          1'b1};
        int cyc; bit seen; int bb;
        for (int k = 0; k < 4; k++) begin
            start_op(va[k], vb[k]);
            wait_rdy(cyc, seen, bb);
            n_total++; if (!seen) $display("FAIL ovf%0d_rdy: no RDY within bound", k); else n_pass++;
            n_total++; if (data_result !== vr[k]) $display("FAIL ovf%0d_result: got %h want %h", k, data_result, vr[k]); else n_pass++;
            n_total++; if (data_exception !== ve[k]) $display("FAIL ovf%0d_exc: got %b want %b", k, data_exception, ve[k]); else n_pass++;
        end
    endtask

    task automatic test_restart();
        int cyc; bit seen; int bb; int early_rdy;
        early_rdy = 0;
        start_op(32'd2, 32'd3);
        // Now in cycle 1; advance to cycle 8 and restart there.
        for (int c = 1; c < 8; c++) begin
            if (data_resultRDY === 1'b1) early_rdy++;
            @(negedge clock);
        end
        if (data_resultRDY === 1'b1) early_rdy++;
        ctrl_MULT = 1'b1;
        data_operandA = 32'd4;
        data_operandB = 32'd5;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        wait_rdy(cyc, seen, bb);
`ifndef MULT_EARLY_TERM_EN
        n_total++; if (early_rdy != 0) $display("FAIL restart_aborted_rdy: got %0d pulses want 0", early_rdy); else n_pass++;
        n_total++; if (cyc != 17) $display("FAIL restart_latency: got cycle %0d want 17", cyc); else n_pass++;
`endif
        n_total++; if (!seen) $display("FAIL restart_rdy: no RDY within bound"); else n_pass++;
        n_total++; if (data_result !== 32'd20) $display("FAIL restart_result: got %h want %h", data_result, 32'd20); else n_pass++;
        @(negedge clock);
        n_total++; if (data_resultRDY !== 1'b0) $display("FAIL restart_single_pulse: rdy got %b want 0", data_resultRDY); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc; bit seen; int bb;
        start_op(32'd7, 32'd9);
        wait_rdy(cyc, seen, bb);
        n_total++; if (!seen) $display("FAIL b2b_first_rdy: no RDY within bound"); else n_pass++;
        n_total++; if (data_result !== 32'd63) $display("FAIL b2b_first_result: got %h want %h", data_result, 32'd63); else n_pass++;
        n_total++; if (bb != 0) $display("FAIL b2b_first_busy: %0d RUN cycles with busy low, want 0", bb); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_done_busy: got %b want 0", busy); else n_pass++;
        // Start the next operation in the DONE cycle.
        ctrl_MULT = 1'b1;
        data_operandA = 32'hFFFF_FFFD;
        data_operandB = 32'd5;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL b2b_second_busy_start: got %b want 1", busy); else n_pass++;
        wait_rdy(cyc, seen, bb);
        n_total++; if (!seen) $display("FAIL b2b_second_rdy: no RDY within bound"); else n_pass++;
        n_total++; if (data_result !== 32'hFFFF_FFF1) $display("FAIL b2b_second_result: got %h want %h", data_result, 32'hFFFF_FFF1); else n_pass++;
        n_total++; if (bb != 0) $display("FAIL b2b_second_busy: %0d RUN cycles with busy low, want 0", bb); else n_pass++;
`ifndef MULT_EARLY_TERM_EN
        n_total++; if (cyc != 17) $display("FAIL b2b_second_latency: got cycle %0d want 17", cyc); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        int cyc; bit seen; int bb; int stray;
`ifdef MULT_EARLY_TERM_EN
        int rst_cyc = 2;
`else
        int rst_cyc = 5;
`endif
        stray = 0;
        start_op(32'h0001_0000, 32'h0001_0000);
        wait_rdy(cyc, seen, bb);
        n_total++; if (data_exception !== 1'b1) $display("FAIL rstmid_pre_exc: got %b want 1", data_exception); else n_pass++;
        start_op(32'd7, 32'd9);
        for (int c = 1; c < rst_cyc; c++) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_total++; if (data_result !== 32'd0) $display("FAIL rstmid_result: got %h want 0", data_result); else n_pass++;
        n_total++; if (data_exception !== 1'b0) $display("FAIL rstmid_exc: got %b want 0", data_exception); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) stray++;
            @(negedge clock);
        end
        n_total++; if (stray != 0) $display("FAIL rstmid_discarded: %0d cycles with rdy/busy, want 0", stray); else n_pass++;
        start_op(32'd7, 32'd9);
        wait_rdy(cyc, seen, bb);
        n_total++; if (!seen) $display("FAIL rstmid_new_rdy: no RDY within bound"); else n_pass++;
        n_total++; if (data_result !== 32'd63) $display("FAIL rstmid_new_result: got %h want %h", data_result, 32'd63); else n_pass++;
`ifndef MULT_EARLY_TERM_EN
        n_total++; if (cyc != 17) $display("FAIL rstmid_new_latency: got cycle %0d want 17", cyc); else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        longint      p;
        logic [31:0] exp_res;
        logic        exp_exc;
        int cyc; bit seen; int bb;
        for (int k = 0; k < 8; k++) begin
            a = $urandom;
            b = (k < 4) ? ($urandom & 32'h0000_FFFF) : $urandom;
            p = longint'($signed(a)) * longint'($signed(b));
            exp_res = p[31:0];
            exp_exc = (p[63:32] != {32{p[31]}});
            start_op(a, b);
            wait_rdy(cyc, seen, bb);
            n_total++; if (data_result !== exp_res) $display("FAIL rand%0d_result: %h*%h got %h want %h", k, a, b, data_result, exp_res); else n_pass++;
            n_total++; if (data_exception !== exp_exc) $display("FAIL rand%0d_exc: %h*%h got %b want %b", k, a, b, data_exception, exp_exc); else n_pass++;
        end
    endtask

`ifdef MULT_EARLY_TERM_EN
    task automatic test_early_term();
        logic [31:0] va [3] = '{32'd123, 32'd123,        32'd3};
        logic [31:0] vb [3] = '{32'd0,   32'hFFFF_FFFF,  32'd5};
        logic [31:0] vr [3] = '{32'd0,   32'hFFFF_FF85,  32'd15};
        int          vc [3] = '{2, 2, 4};
        int cyc; bit seen; int bb;
        for (int k = 0; k < 3; k++) begin
            start_op(va[k], vb[k]);
            wait_rdy(cyc, seen, bb);
            n_total++; if (data_result !== vr[k]) $display("FAIL early%0d_result: got %h want %h", k, data_result, vr[k]); else n_pass++;
            n_total++; if (cyc != vc[k]) $display("FAIL early%0d_latency: got cycle %0d want %0d", k, cyc, vc[k]); else n_pass++;
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        ctrl_MULT = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        test_reset();
        test_signed();
        test_overflow();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef MULT_EARLY_TERM_EN
        test_early_term();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
